// File: rtl/udp_reg_pkg.sv
// Shared definitions for the UDP register bridge: command opcodes, response
// flag bits and the bridge FSM state encoding.
package udp_reg_pkg;

    localparam logic [7:0]  OP_WR        = 8'h01;
    localparam logic [7:0]  OP_RD        = 8'h02;
    localparam logic [7:0]  RESP_FLAG    = 8'h80;
    localparam logic [7:0]  ERR_FLAG     = 8'h40;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_HDR  = 3'd1,
        CMD     = 3'd2,
        WR      = 3'd3,
        RD_WAIT = 3'd4,
        RESP    = 3'd5,
        DRAIN   = 3'd6
    } state_t;

endpackage

// File: rtl/udp_reg_bridge.sv
// UDP register-access endpoint: each 64-bit command word on CMD_PORT becomes one
// local register write or read and produces one response word in the reply frame.
module udp_reg_bridge
    import udp_reg_pkg::*;
#(
    parameter logic [15:0] CMD_PORT   = 16'd5000,
    parameter int unsigned RD_TIMEOUT = 255,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80A64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [31:0] s_udp_ip_source_ip,
    input  logic [15:0] s_udp_source_port,
    input  logic [15:0] s_udp_dest_port,
    input  logic [15:0] s_udp_length,
    input  logic [63:0] s_udp_payload_axis_tdata,
    input  logic [7:0]  s_udp_payload_axis_tkeep,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_udp_ip_dscp,
    output logic [1:0]  m_udp_ip_ecn,
    output logic [7:0]  m_udp_ip_ttl,
    output logic [31:0] m_udp_ip_source_ip,
    output logic [31:0] m_udp_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [63:0] m_udp_payload_axis_tdata,
    output logic [7:0]  m_udp_payload_axis_tkeep,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wr_data,
    input  logic [31:0] reg_rd_data,
    input  logic        reg_rd_valid,
    output logic [31:0] cmd_count,
    output logic [15:0] err_count,
    output logic [2:0]  dbg_state
);

    // All handshakes are valid/ready: a transfer happens on a rising edge where
    // both are high; valid, once raised, holds with stable data until accepted.

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(RD_TIMEOUT);

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  req_rsvd;

    logic [7:0]  beat_op;
    logic [7:0]  beat_rsvd;
    logic [15:0] beat_addr;
    logic [31:0] beat_data;
    logic        beat_full;

    assign beat_op   = s_udp_payload_axis_tdata[63:56];
    assign beat_rsvd = s_udp_payload_axis_tdata[55:48];
    assign beat_addr = s_udp_payload_axis_tdata[47:32];
    assign beat_data = s_udp_payload_axis_tdata[31:0];
    assign beat_full = (s_udp_payload_axis_tkeep == 8'hFF);

    assign m_udp_ip_dscp  = 6'd0;
    assign m_udp_ip_ecn   = 2'd0;
    assign m_udp_ip_ttl   = 8'd64;
    assign m_udp_checksum = 16'd0;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            timer                     <= '0;
            req_rsvd                  <= '0;
            s_udp_hdr_ready           <= 1'b0;
            s_udp_payload_axis_tready <= 1'b0;
            m_udp_hdr_valid           <= 1'b0;
            m_udp_ip_source_ip        <= '0;
            m_udp_ip_dest_ip          <= '0;
            m_udp_source_port         <= '0;
            m_udp_dest_port           <= '0;
            m_udp_length              <= '0;
            m_udp_payload_axis_tdata  <= '0;
            m_udp_payload_axis_tkeep  <= '0;
            m_udp_payload_axis_tvalid <= 1'b0;
            m_udp_payload_axis_tlast  <= 1'b0;
            m_udp_payload_axis_tuser  <= 1'b0;
            reg_wr_en                 <= 1'b0;
            reg_rd_en                 <= 1'b0;
            reg_addr                  <= '0;
            reg_wr_data               <= '0;
            cmd_count                 <= '0;
            err_count                 <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    // Ready rises one cycle after reset release, not during reset.
                    if (s_udp_hdr_ready && s_udp_hdr_valid) begin
                        s_udp_hdr_ready    <= 1'b0;
                        m_udp_ip_dest_ip   <= s_udp_ip_source_ip;
                        m_udp_ip_source_ip <= LOCAL_IP;
                        m_udp_source_port  <= s_udp_dest_port;
                        m_udp_dest_port    <= s_udp_source_port;
                        m_udp_length       <= s_udp_length;
                        if (s_udp_dest_port == CMD_PORT) begin
                            m_udp_hdr_valid <= 1'b1;
                            state           <= TX_HDR;
                        end else begin
                            s_udp_payload_axis_tready <= 1'b1;
                            state                     <= DRAIN;
                        end
                    end else begin
                        s_udp_hdr_ready <= 1'b1;
                    end
                end
                TX_HDR: begin
                    if (m_udp_hdr_ready) begin
                        m_udp_hdr_valid           <= 1'b0;
                        s_udp_payload_axis_tready <= 1'b1;
                        state                     <= CMD;
                    end
                end
                CMD: begin
                    if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tready) begin
                        s_udp_payload_axis_tready <= 1'b0;
                        m_udp_payload_axis_tkeep  <= s_udp_payload_axis_tkeep;
                        m_udp_payload_axis_tlast  <= s_udp_payload_axis_tlast;
                        m_udp_payload_axis_tuser  <= s_udp_payload_axis_tuser;
                        req_rsvd                  <= beat_rsvd;
                        if (beat_full && beat_op == OP_WR) begin
                            reg_addr    <= beat_addr;
                            reg_wr_data <= beat_data;
                            reg_wr_en   <= 1'b1;
                            state       <= WR;
                        end else if (beat_full && beat_op == OP_RD) begin
                            reg_addr  <= beat_addr;
                            reg_rd_en <= 1'b1;
                            timer     <= '0;
                            state     <= RD_WAIT;
                        end else begin
                            // Unknown opcode or partial word: echo it back flagged.
                            m_udp_payload_axis_tdata  <= {beat_op | RESP_FLAG | ERR_FLAG,
                                                          beat_rsvd, beat_addr, beat_data};
                            m_udp_payload_axis_tvalid <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 16'd1;
                            state <= RESP;
                        end
                    end
                end
                WR: begin
                    m_udp_payload_axis_tdata  <= {OP_WR | RESP_FLAG, req_rsvd, reg_addr, reg_wr_data};
                    m_udp_payload_axis_tvalid <= 1'b1;
                    state                     <= RESP;
                end
                RD_WAIT: begin
                    // Valid data takes priority over a coincident timeout.
                    if (reg_rd_valid) begin
                        m_udp_payload_axis_tdata  <= {OP_RD | RESP_FLAG, req_rsvd, reg_addr, reg_rd_data};
                        m_udp_payload_axis_tvalid <= 1'b1;
                        state                     <= RESP;
                    end else if (timer == TIMEOUT_LIMIT) begin
                        m_udp_payload_axis_tdata  <= {OP_RD | RESP_FLAG | ERR_FLAG, req_rsvd,
                                                      reg_addr, TIMEOUT_DATA};
                        m_udp_payload_axis_tvalid <= 1'b1;
                        if (err_count != '1) err_count <= err_count + 16'd1;
                        state <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    if (m_udp_payload_axis_tready) begin
                        m_udp_payload_axis_tvalid <= 1'b0;
                        if (cmd_count != '1) cmd_count <= cmd_count + 32'd1;
                        if (m_udp_payload_axis_tlast) begin
                            s_udp_hdr_ready <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            s_udp_payload_axis_tready <= 1'b1;
                            state                     <= CMD;
                        end
                    end
                end
                DRAIN: begin
                    if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
                        s_udp_payload_axis_tready <= 1'b0;
                        s_udp_hdr_ready           <= 1'b1;
                        state                     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_reg_bridge.sv
// Directed bench for udp_reg_bridge: writes, reads, read timeout, foreign-port
// drain, partial word under TX backpressure, and reset during a read.
module tb_udp_reg_bridge;
    import udp_reg_pkg::*;

    localparam logic [31:0] REQ_IP   = 32'h0A000001;
    localparam logic [31:0] LOCAL_IP = 32'hC0A80A64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_udp_hdr_valid, s_udp_hdr_ready;
    logic [31:0] s_udp_ip_source_ip;
    logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_length;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic        m_udp_hdr_valid, m_udp_hdr_ready;
    logic [5:0]  m_udp_ip_dscp;
    logic [1:0]  m_udp_ip_ecn;
    logic [7:0]  m_udp_ip_ttl;
    logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
    logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        reg_wr_en, reg_rd_en;
    logic [15:0] reg_addr;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic        reg_rd_valid;
    logic [31:0] cmd_count;
    logic [15:0] err_count;
    logic [2:0]  dbg_state;

    udp_reg_bridge #(
        .CMD_PORT  (16'd5000),
        .RD_TIMEOUT(16),
        .LOCAL_IP  (LOCAL_IP)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_udp_hdr_valid           (s_udp_hdr_valid),
        .s_udp_hdr_ready           (s_udp_hdr_ready),
        .s_udp_ip_source_ip        (s_udp_ip_source_ip),
        .s_udp_source_port         (s_udp_source_port),
        .s_udp_dest_port           (s_udp_dest_port),
        .s_udp_length              (s_udp_length),
        .s_udp_payload_axis_tdata  (s_tdata),
        .s_udp_payload_axis_tkeep  (s_tkeep),
        .s_udp_payload_axis_tvalid (s_tvalid),
        .s_udp_payload_axis_tready (s_tready),
        .s_udp_payload_axis_tlast  (s_tlast),
        .s_udp_payload_axis_tuser  (s_tuser),
        .m_udp_hdr_valid           (m_udp_hdr_valid),
        .m_udp_hdr_ready           (m_udp_hdr_ready),
        .m_udp_ip_dscp             (m_udp_ip_dscp),
        .m_udp_ip_ecn              (m_udp_ip_ecn),
        .m_udp_ip_ttl              (m_udp_ip_ttl),
        .m_udp_ip_source_ip        (m_udp_ip_source_ip),
        .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
        .m_udp_source_port         (m_udp_source_port),
        .m_udp_dest_port           (m_udp_dest_port),
        .m_udp_length              (m_udp_length),
        .m_udp_checksum            (m_udp_checksum),
        .m_udp_payload_axis_tdata  (m_tdata),
        .m_udp_payload_axis_tkeep  (m_tkeep),
        .m_udp_payload_axis_tvalid (m_tvalid),
        .m_udp_payload_axis_tready (m_tready),
        .m_udp_payload_axis_tlast  (m_tlast),
        .m_udp_payload_axis_tuser  (m_tuser),
        .reg_wr_en                 (reg_wr_en),
        .reg_rd_en                 (reg_rd_en),
        .reg_addr                  (reg_addr),
        .reg_wr_data               (reg_wr_data),
        .reg_rd_data               (reg_rd_data),
        .reg_rd_valid              (reg_rd_valid),
        .cmd_count                 (cmd_count),
        .err_count                 (err_count),
        .dbg_state                 (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [9:0]  exp_meta_q[$];
    logic [63:0] got_q[$];
    logic [9:0]  got_meta_q[$];

    int wr_pulses = 0;
    int rd_pulses = 0;
    int hdr_valid_cycles = 0;
    logic [31:0] cap_src_ip, cap_dst_ip;
    logic [15:0] cap_sport, cap_dport, cap_len;
    logic [7:0]  cap_ttl;
    logic        toggle_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        if (reg_wr_en) wr_pulses++;
        if (reg_rd_en) rd_pulses++;
        if (m_udp_hdr_valid) hdr_valid_cycles++;
        if (m_udp_hdr_valid && m_udp_hdr_ready) begin
            cap_src_ip = m_udp_ip_source_ip;
            cap_dst_ip = m_udp_ip_dest_ip;
            cap_sport  = m_udp_source_port;
            cap_dport  = m_udp_dest_port;
            cap_len    = m_udp_length;
            cap_ttl    = m_udp_ip_ttl;
        end
        if (m_tvalid && m_tready) begin
            got_q.push_back(m_tdata);
            got_meta_q.push_back({m_tkeep, m_tlast, m_tuser});
        end
    end

    // TX payload ready: held high, or toggled every cycle when backpressure is on.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) m_tready = ~m_tready;
            else m_tready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [15:0] sport, input logic [15:0] dport, input logic [15:0] len);
        logic ok = 1'b0;
        s_udp_hdr_valid    = 1'b1;
        s_udp_ip_source_ip = REQ_IP;
        s_udp_source_port  = sport;
        s_udp_dest_port    = dport;
        s_udp_length       = len;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (s_udp_hdr_ready) ok = 1'b1;
            tick();
        end
        s_udp_hdr_valid = 1'b0;
        check("hdr_accept", ok, 1);
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input logic last, input logic user);
        logic ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tkeep  = keep;
        s_tlast  = last;
        s_tuser  = user;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (s_tready) ok = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("beat_accept", ok, 1);
    endtask

    task automatic sb_expect(input logic [63:0] data, input logic [7:0] keep, input logic last, input logic user);
        exp_q.push_back(data);
        exp_meta_q.push_back({keep, last, user});
    endtask

    task automatic wait_replies(input int n);
        for (int i = 0; i < 100 && got_q.size() < n; i++) tick();
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_reply_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_reply_data"}, got_q.pop_front(), exp_q.pop_front());
            check({tag, "_reply_keep_last_user"}, got_meta_q.pop_front(), exp_meta_q.pop_front());
        end
        got_q.delete();
        got_meta_q.delete();
        exp_q.delete();
        exp_meta_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0, r0, hv0;
        rst_n = 1'b0;
        s_udp_hdr_valid = 1'b0;
        s_udp_ip_source_ip = '0;
        s_udp_source_port = '0;
        s_udp_dest_port = '0;
        s_udp_length = '0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        m_udp_hdr_ready = 1'b1;
        reg_rd_data = '0;
        reg_rd_valid = 1'b0;
        repeat (3) tick();

        check("rst_hdr_ready", s_udp_hdr_ready, 0);
        check("rst_m_hdr_valid", m_udp_hdr_valid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_wr_rd_en", {reg_wr_en, reg_rd_en}, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_counters", {cmd_count, err_count}, 0);
        check("rst_dest_ip", m_udp_ip_dest_ip, 0);
        check("rst_ttl", m_udp_ip_ttl, 64);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();
        check("post_rst_hdr_ready", s_udp_hdr_ready, 1);

        // Single write
        send_hdr(16'h1111, 16'd5000, 16'd16);
        check("t1_hdr_valid_latency", m_udp_hdr_valid, 1);
        send_beat(64'h0100_0010_1234_5678, 8'hFF, 1'b1, 1'b0);
        sb_expect(64'h8100_0010_1234_5678, 8'hFF, 1'b1, 1'b0);
        check("t1_wr_en", reg_wr_en, 1);
        check("t1_wr_addr", reg_addr, 16'h0010);
        check("t1_wr_data", reg_wr_data, 32'h1234_5678);
        check("t1_no_resp_yet", m_tvalid, 0);
        tick();
        check("t1_wr_en_one_cycle", reg_wr_en, 0);
        check("t1_resp_valid", m_tvalid, 1);
        check("t1_resp_word", m_tdata, 64'h8100_0010_1234_5678);
        tick();
        check("t1_cmd_count", cmd_count, 1);
        check("t1_wr_pulses", wr_pulses, 1);
        check("t1_hdr_dest_ip", cap_dst_ip, REQ_IP);
        sb_drain("t1");

        // Read answered after 5 cycles, with TX header backpressure first
        m_udp_hdr_ready = 1'b0;
        send_hdr(16'h1111, 16'd5000, 16'd16);
        check("t2_hdr_valid", m_udp_hdr_valid, 1);
        repeat (3) tick();
        check("t2_hdr_valid_held", m_udp_hdr_valid, 1);
        check("t2_no_tready_in_hdr", s_tready, 0);
        m_udp_hdr_ready = 1'b1;
        send_beat(64'h0200_0020_0000_0000, 8'hFF, 1'b1, 1'b0);
        sb_expect(64'h8200_0020_CAFE_F00D, 8'hFF, 1'b1, 1'b0);
        check("t2_rd_en", reg_rd_en, 1);
        check("t2_rd_addr", reg_addr, 16'h0020);
        repeat (5) tick();
        check("t2_waiting", m_tvalid, 0);
        reg_rd_valid = 1'b1;
        reg_rd_data  = 32'hCAFE_F00D;
        tick();
        reg_rd_valid = 1'b0;
        reg_rd_data  = 32'h0;
        check("t2_resp_valid", m_tvalid, 1);
        check("t2_resp_word", m_tdata, 64'h8200_0020_CAFE_F00D);
        tick();
        check("t2_rd_pulses", rd_pulses, 1);
        check("t2_cmd_count", cmd_count, 2);
        sb_drain("t2");

        // Stray read-valid while idle, then a read that times out
        reg_rd_valid = 1'b1;
        reg_rd_data  = 32'h5555_5555;
        tick();
        reg_rd_valid = 1'b0;
        send_hdr(16'h1111, 16'd5000, 16'd16);
        send_beat(64'h0200_0020_0000_0000, 8'hFF, 1'b1, 1'b0);
        sb_expect(64'hC200_0020_DEAD_BEEF, 8'hFF, 1'b1, 1'b0);
        check("t3_rd_en", reg_rd_en, 1);
        repeat (16) tick();
        check("t3_not_before_17", m_tvalid, 0);
        tick();
        check("t3_resp_at_17", m_tvalid, 1);
        check("t3_resp_word", m_tdata, 64'hC200_0020_DEAD_BEEF);
        tick();
        check("t3_err_count", err_count, 1);
        check("t3_cmd_count", cmd_count, 3);
        sb_drain("t3");

        // Foreign port: 4 beats of valid-looking writes must be dropped
        hv0 = hdr_valid_cycles;
        w0  = wr_pulses;
        r0  = rd_pulses;
        send_hdr(16'h2222, 16'd1234, 16'd40);
        for (int i = 0; i < 4; i++)
            send_beat(64'h0100_0070_0000_0000 + 64'(i), 8'hFF, (i == 3), 1'b0);
        repeat (2) tick();
        check("t4_no_hdr_valid", hdr_valid_cycles, hv0);
        check("t4_no_wr", wr_pulses, w0);
        check("t4_no_rd", rd_pulses, r0);
        check("t4_no_reply", got_q.size(), 0);
        check("t4_back_to_idle", s_udp_hdr_ready, 1);
        send_hdr(16'h3333, 16'd5000, 16'd16);
        send_beat(64'h0100_0030_A5A5_A5A5, 8'hFF, 1'b1, 1'b0);
        sb_expect(64'h8100_0030_A5A5_A5A5, 8'hFF, 1'b1, 1'b0);
        wait_replies(1);
        tick();
        sb_drain("t4");
        check("t4_cmd_count", cmd_count, 4);
        check("t4_addr", reg_addr, 16'h0030);

        // 3-word frame, partial poisoned last word, TX payload ready toggling
        w0 = wr_pulses;
        toggle_en = 1'b1;
        send_hdr(16'h4444, 16'd5000, 16'd32);
        send_beat(64'h0100_0040_1111_1111, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h0100_0044_2222_2222, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h0100_0048_3333_3333, 8'h0F, 1'b1, 1'b1);
        sb_expect(64'h8100_0040_1111_1111, 8'hFF, 1'b0, 1'b0);
        sb_expect(64'h8100_0044_2222_2222, 8'hFF, 1'b0, 1'b0);
        sb_expect(64'hC100_0048_3333_3333, 8'h0F, 1'b1, 1'b1);
        wait_replies(3);
        toggle_en = 1'b0;
        tick();
        sb_drain("t5");
        check("t5_hdr_sport", cap_sport, 16'd5000);
        check("t5_hdr_dport", cap_dport, 16'h4444);
        check("t5_hdr_len", cap_len, 16'd32);
        check("t5_hdr_dst_ip", cap_dst_ip, REQ_IP);
        check("t5_hdr_src_ip", cap_src_ip, LOCAL_IP);
        check("t5_hdr_ttl", cap_ttl, 64);
        check("t5_wr_pulses", wr_pulses - w0, 2);
        check("t5_err_count", err_count, 2);
        check("t5_cmd_count", cmd_count, 7);

        // Reset while waiting for read data
        send_hdr(16'h5555, 16'd5000, 16'd8);
        send_beat(64'h0200_0060_0000_0000, 8'hFF, 1'b1, 1'b0);
        repeat (2) tick();
        check("t6_in_rd_wait", dbg_state, RD_WAIT);
        rst_n = 1'b0;
        #1;
        check("t6_rst_hdr_ready", s_udp_hdr_ready, 0);
        check("t6_rst_valids", {m_udp_hdr_valid, m_tvalid, s_tready}, 0);
        check("t6_rst_bus", {reg_wr_en, reg_rd_en, reg_addr}, 0);
        check("t6_rst_counters", {cmd_count, err_count}, 0);
        check("t6_rst_hdr", m_udp_dest_port, 0);
        check("t6_rst_tdata", m_tdata, 0);
        check("t6_rst_state", dbg_state, IDLE);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_idle_ready", s_udp_hdr_ready, 1);
        check("t6_idle_state", dbg_state, IDLE);
        check("t6_no_reply", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_reg_bridge.md
# udp_reg_bridge

Register-access endpoint on the 64-bit UDP user interface of `udp_complete_64`, taking the place of the plain payload loopback. Frames arriving on `CMD_PORT` carry 64-bit command words. Each word drives one write or read on a simple local register bus, and the block returns one response word per command in a UDP reply to the sender. Frames for any other port are accepted and discarded so the UDP stack never stalls.

## Interface
- `CMD_PORT`, 16'd5000: UDP destination port served.
- `RD_TIMEOUT`, 255: cycles to wait for `reg_rd_valid` before a read is declared failed; 1..65535.
- `LOCAL_IP`, 32'hC0A80A64: source IP placed in replies.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `s_udp_hdr_valid`/`s_udp_hdr_ready` in/out 1: RX header handshake.
- `s_udp_ip_source_ip` in 32: requester IP.
- `s_udp_source_port`, `s_udp_dest_port`, `s_udp_length` in 16 each.
- `s_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser`: 64/8/1/1/1/1, RX payload (tready out).
- `m_udp_hdr_valid`/`m_udp_hdr_ready` out/in 1: TX header handshake.
- `m_udp_ip_dscp` 6, `m_udp_ip_ecn` 2, `m_udp_ip_ttl` 8, `m_udp_ip_source_ip` 32, `m_udp_ip_dest_ip` 32, `m_udp_source_port` 16, `m_udp_dest_port` 16, `m_udp_length` 16, `m_udp_checksum` 16: all out.
- `m_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser`: TX payload (tready in).
- `reg_wr_en` out 1, `reg_rd_en` out 1, `reg_addr` out 16, `reg_wr_data` out 32.
- `reg_rd_data` in 32, `reg_rd_valid` in 1.
- `cmd_count` out 32: completed commands.
- `err_count` out 16: timeouts, unknown opcodes and malformed words.

## Operation
- Command word layout: [63:56] opcode, [55:48] reserved, [47:32] addr, [31:0] data.
- Opcode 8'h01 is a write; 8'h02 is a read.
- Response word layout: opcode|8'h80 with bit6 set on error, reserved echoed, addr echoed, data field = write data (write), read data (read), or 32'hDEADBEEF (read timeout).
- Reply header fields:
  - dest_ip = requester IP; source_ip = `LOCAL_IP`.
  - Ports swapped.
  - length = `s_udp_length`.
  - ttl = 64; dscp, ecn and checksum = 0.
- FSM states: IDLE, TX_HDR, CMD, WR, RD_WAIT, RESP, DRAIN.
  - IDLE: `s_udp_hdr_ready`=1. On accept, latch the header fields. dest_port==`CMD_PORT` → TX_HDR; otherwise → DRAIN.
  - TX_HDR: `m_udp_hdr_valid`=1 until `m_udp_hdr_ready`, then → CMD.
  - CMD: `s_udp_payload_axis_tready`=1. On beat, latch data/keep/last/user.
    - Full word (tkeep==8'hFF), write → WR.
    - Full word, read → RD_WAIT with `reg_rd_en` pulse.
    - Unknown opcode or partial word → RESP, no bus access, error counted.
  - WR: `reg_wr_en` high for exactly one cycle, then → RESP.
  - RD_WAIT: wait for `reg_rd_valid` and capture `reg_rd_data`. If the timer reaches `RD_TIMEOUT` first, use the timeout value and count an error. Then → RESP.
  - RESP: `m_udp_payload_axis_tvalid`=1; tkeep and tlast are copied from the request beat. tuser = request tuser, so a bad RX frame poisons the reply. On ready: last → IDLE, else → CMD.
  - DRAIN: tready=1 and all beats are discarded; leave to IDLE on the tlast beat.
- Partial words are echoed with the original tkeep and the data field unchanged; bit6 is set.
- `cmd_count` increments on each RESP handshake. Both counters saturate.

## Timing
- Reset values: all valid, ready and enable outputs are 0; counters are 0; FSM is IDLE.
- Header and register-bus outputs are 0 at reset. `m_udp_ip_ttl` is the constant 64.
- Header-accept to `m_udp_hdr_valid`: 1 cycle.
- Write command: beat accepted → `reg_wr_en` on the next cycle → response valid the cycle after.
- Read command: beat accepted → `reg_rd_en` on the next cycle. `reg_rd_valid` in cycle N → response valid in N+1.
- `reg_rd_valid` at the same time as timer expiry: the valid data wins.
- `reg_rd_valid` outside RD_WAIT is ignored.
- `reg_addr` and `reg_wr_data` stay stable from the enable pulse until the next command.
- Peak throughput is one command per 3 cycles; write/read cadence is never back-to-back.
- Reset mid-frame aborts the transaction. The partial reply is not completed; the upstream stack handles truncation.

## Structure
- Shared package `udp_reg_pkg` holds:
  - opcode constants OP_WR=8'h01, OP_RD=8'h02;
  - RESP_FLAG=8'h80, ERR_FLAG=8'h40, TIMEOUT_DATA=32'hDEADBEEF;
  - the FSM state enum.
- Single module; no sub-module needed. The timeout counter is inline, 16 bits wide.

## Test plan
- Port 5000 frame with one word 64'h01_00_0010_12345678: `reg_wr_en` pulses once, with addr 16'h0010 and data 32'h12345678; reply word is 64'h81_00_0010_12345678; `cmd_count`=1.
- Read word 64'h02_00_0020_00000000 with `reg_rd_valid` 5 cycles later carrying 32'hCAFEF00D: reply word is 64'h82_00_0020_CAFEF00D.
- Read with no `reg_rd_valid` and `RD_TIMEOUT`=16: reply arrives 17 cycles after `reg_rd_en`; word is 64'hC2_00_0020_DEADBEEF; `err_count`=1.
- Port 1234 frame of 4 beats: all beats accepted, no `m_udp_hdr_valid`, no bus activity; the next port-5000 frame is served normally.
- 3-word frame with last tkeep 8'h0F and tuser=1, while `m_udp_payload_axis_tready` is toggled every cycle:
  - reply header has ports swapped and length equal to the request;
  - the last reply beat has tkeep 8'h0F, tuser=1 and bit6 set;
  - no data is lost under backpressure.
- `rst_n` asserted during RD_WAIT: all outputs are 0 immediately; after release, IDLE with `s_udp_hdr_ready`=1.
